// File: rtl/cpu5_ifu.sv
// cpu5_ifu -- instruction fetch unit for the cpu5 RV32I core.
//
// Holds the fetch PC, issues one outstanding word fetch at a time to
// instruction memory, and captures each returned word into the IF/ID
// register that feeds the decoder. A one-cycle redirect flushes the IF/ID
// register and restarts fetch at the target; a response that was in flight
// at redirect time is drained and thrown away.
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, word address)
//   imem_resp_*       fetch response (no back-pressure, latency >= 1)
//   redirect_*        taken branch/jump pulse and target from execute
//   id_ready          decoder consumes the IF/ID contents this cycle
//   if_*              IF/ID register: valid, word, PC and decoded fields
module cpu5_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_op,
  output logic [2:0]      if_funct3,
  output logic [6:0]      if_funct7
);

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // ready to issue a fetch
    S_WAIT = 2'd1,  // fetch outstanding, response will be captured
    S_DROP = 2'd2   // fetch outstanding, response will be discarded
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] fetch_pc;
  logic            hs, capture, consume;

  assign imem_req_addr = fetch_pc;
  assign if_op         = if_instr[6:0];
  assign if_funct3     = if_instr[14:12];
  assign if_funct7     = if_instr[31:25];

  // A request is only issued when IF/ID is empty or being drained this
  // cycle, so the register is always free by the time the word returns.
  always_comb begin
    imem_req_valid = (state == S_REQ) & (~if_valid | id_ready) & ~reset;
    hs             = imem_req_valid & imem_req_ready;
    capture        = (state == S_WAIT) & imem_resp_valid & ~redirect_valid;
    consume        = if_valid & id_ready;
    state_n        = state;
    if (redirect_valid) begin
      // Drain if a fetch is still in flight after this cycle: either one
      // was just accepted, or the pending one has not answered yet.
      if ((state == S_REQ) ? hs : ~imem_resp_valid) state_n = S_DROP;
      else                                          state_n = S_REQ;
    end else begin
      unique case (state)
        S_REQ:         if (hs)              state_n = S_WAIT;
        S_WAIT,
        S_DROP:        if (imem_resp_valid) state_n = S_REQ;
        default:                            state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_REQ;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= NOP;
      if_pc    <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      if_valid <= 1'b0;
    end else if (capture) begin
      // Capture may coincide with consumption; the new word simply replaces
      // the one the decoder is taking.
      if_instr <= imem_resp_data;
      if_pc    <= fetch_pc;
      if_valid <= 1'b1;
      fetch_pc <= fetch_pc + XLEN'(4);
    end else if (consume) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu5_ifu.sv
// Testbench for cpu5_ifu: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a
// transaction-level model of the fetch stream and a latency-programmable
// instruction memory.
module tb_cpu5_ifu;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic [6:0]  if_op, if_funct7;
  logic [2:0]  if_funct3;

  cpu5_ifu #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_op(if_op), .if_funct3(if_funct3), .if_funct7(if_funct7)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // memory state
  int          lat = 1;
  logic        stray_en = 1'b0;
  logic        pend = 1'b0, plive = 1'b0;
  int          pcnt = 0;
  logic [31:0] paddr = '0;
  logic        rv_real = 1'b0, rv_live = 1'b0;
  logic [31:0] rv_addr = '0;

  // fetch-stream model
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = RESET_PC, m_instr = NOP, exp_pc = RESET_PC;
  logic [31:0] watch_pc = 32'h1;
  logic        watch_hit = 1'b0;
  int          ndeliv = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Instruction memory: answers the accepted request after `lat` cycles,
  // optionally emits stray responses while nothing is outstanding.
  task automatic mem_drive();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    rv_real         = 1'b0;
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = memf(paddr);
        rv_real = 1'b1; rv_live = plive; rv_addr = paddr;
        pend = 1'b0;
      end
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      imem_resp_valid = 1'b1;
    end
  endtask

  // Checks the current cycle against the model, then advances the model
  // by the events of this cycle.
  task automatic model();
    logic outst;
    if (reset) begin
      chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      pend = 1'b0; m_valid = 1'b0; m_pc = RESET_PC; m_instr = NOP; exp_pc = RESET_PC;
      return;
    end
    outst = pend || rv_real;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, !outst && (!m_valid || id_ready)});
    chk("addr_align", {30'b0, imem_req_addr[1:0]}, 32'd0);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("if_pc", if_pc, m_pc);
      chk("if_instr", if_instr, m_instr);
      chk("if_op", {25'b0, if_op}, {25'b0, m_instr[6:0]});
      chk("if_funct3", {29'b0, if_funct3}, {29'b0, m_instr[14:12]});
      chk("if_funct7", {25'b0, if_funct7}, {25'b0, m_instr[31:25]});
    end
    if (if_valid && if_pc == watch_pc) watch_hit = 1'b1;
    if (m_valid && id_ready) begin exp_pc = exp_pc + 32'd4; ndeliv++; end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      pend = 1'b1; plive = 1'b1; pcnt = lat; paddr = exp_pc;
    end
    if (redirect_valid) begin
      m_valid = 1'b0; plive = 1'b0; exp_pc = redirect_pc & ~32'd3;
    end else if (rv_real && rv_live) begin
      m_valid = 1'b1; m_pc = rv_addr; m_instr = memf(rv_addr);
    end else if (m_valid && id_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic half();
    @(negedge clk);
    model();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    mem_drive();
  endtask

  // Run until a handshake; with first=1 the first handshake must carry
  // `addr`, otherwise keep going until one with `addr` occurs.
  task automatic wait_hs(input logic [31:0] addr, input logic first, input string nm);
    for (int i = 0; i < 60; i++) begin
      half();
      if (imem_req_valid && imem_req_ready && (first || imem_req_addr == addr)) begin
        chk(nm, imem_req_addr, addr);
        tick();
        return;
      end
      tick();
    end
    checks++; errors++;
    $display("FAIL %s: no handshake within 60 cycles, expected addr 0x%h", nm, addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    tick();
    half(); tick();
    reset = 1'b0;

    // cycle 0: first fetch at RESET_PC
    half();
    chk("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c0_req_addr", imem_req_addr, 32'h0);
    chk("c0_if_valid", {31'b0, if_valid}, 32'd0);
    tick();
    half(); chk("c1_req_valid", {31'b0, imem_req_valid}, 32'd0); tick();
    // cycle 2: instruction at 0 visible; decoder stalls
    id_ready = 1'b0;
    half();
    chk("c2_if_valid", {31'b0, if_valid}, 32'd1);
    chk("c2_if_pc", if_pc, 32'h0);
    chk("c2_if_op", {25'b0, if_op}, 32'h13);
    chk("c2_if_funct3", {29'b0, if_funct3}, 32'd0);
    chk("c2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    tick();
    half();
    chk("c3_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("c3_if_instr_held", if_instr, 32'h0050_0093);
    tick();
    id_ready = 1'b1;
    half();
    chk("c4_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c4_req_addr", imem_req_addr, 32'h4);
    tick();
    half(); tick();
    // cycle 6: instruction at 4, memory stalls 3 cycles on fetch of 8
    imem_req_ready = 1'b0;
    half();
    chk("c6_if_pc", if_pc, 32'h4);
    chk("c6_if_instr", if_instr, 32'h00A0_0113);
    chk("c6_req_addr", imem_req_addr, 32'h8);
    tick();
    repeat (2) begin
      half();
      chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("stall_req_addr", imem_req_addr, 32'h8);
      tick();
    end
    imem_req_ready = 1'b1;
    half();
    chk("c9_hs_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c9_hs_addr", imem_req_addr, 32'h8);
    tick();

    // redirect while waiting on a 3-cycle fetch of 0x10
    lat = 3;
    wait_hs(32'h10, 1'b0, "hs_0x10");
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    half(); tick();
    watch_pc = 32'h10; watch_hit = 1'b0;
    wait_hs(32'h100, 1'b1, "redir_addr_0x100");
    chk("dropped_0x10_seen", {31'b0, watch_hit}, 32'd0);
    watch_pc = 32'h1;

    // redirect coinciding with the response for 0x20
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    half(); tick();
    lat = 2;
    wait_hs(32'h20, 1'b1, "redir_addr_0x20");
    half(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    half(); tick();
    half();
    chk("coinc_if_valid", {31'b0, if_valid}, 32'd0);
    chk("coinc_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("coinc_req_addr", imem_req_addr, 32'h200);
    tick();

    // wrap at the top of the address space, then reset mid-fetch
    lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    half(); tick();
    wait_hs(32'hFFFF_FFFC, 1'b1, "redir_addr_top");
    lat = 3;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        half();
        if (if_valid) begin
          seen = 1'b1;
          chk("top_if_pc", if_pc, 32'hFFFF_FFFC);
          chk("top_if_instr", if_instr, memf(32'hFFFF_FFFC));
          chk("wrap_req_addr", imem_req_addr, 32'h0);
          chk("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
        end
        tick();
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL top_if_valid: never asserted, expected pc 0xfffffffc");
      end
    end
    reset = 1'b1;
    half(); tick();
    reset = 1'b0;
    half();
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, RESET_PC);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    tick();

    // randomized traffic
    stray_en = 1'b1;
    ndeliv = 0;
    for (int i = 0; i < 4000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      lat            = $urandom_range(1, 4);
      reset          = ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                   : $urandom;
      half(); tick();
    end
    reset = 1'b0;
    chk("rand_progress", {31'b0, ndeliv >= 300}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
